// File: rtl/controlador_registrador_pkg.sv
// Shared definitions for the shift-register sequencer: FSM state encoding and default word length.
package controlador_registrador_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/controlador_registrador_arbitro_rr2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the requester that was not served last.
module arbitro_rr2
    import controlador_registrador_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_id_i,
    output logic any_o,
    output logic win_id_o
);

    always_comb begin
        any_o    = req0_i | req1_i;
        win_id_o = (req0_i & req1_i) ? ~last_id_i : req1_i;
    end

endmodule

// File: rtl/controlador_registrador.sv
// Arbitrates two word requesters and streams the granted word serially into an
// external shift register: clear, WIDTH enabled shifts, then a done pulse.
module controlador_registrador
    import controlador_registrador_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             sr_clr_o,
    output logic             sr_en_o,
    output logic             sr_in_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             id_q, id_d;
    logic             last_id_q, last_id_d;

    logic             arb_any;
    logic             arb_win_id;
    logic [CW-1:0]    bit_idx;

    arbitro_rr2 u_arbitro (
        .req0_i   (req0_i),
        .req1_i   (req1_i),
        .last_id_i(last_id_q),
        .any_o    (arb_any),
        .win_id_o (arb_win_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
        end
    end

    // The counter runs WIDTH-1 down to 0; MSB-first uses it directly as the bit index.
    always_comb begin
        bit_idx = MSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        id_d      = id_q;
        last_id_d = last_id_q;

        gnt0_o    = 1'b0;
        gnt1_o    = 1'b0;
        sr_clr_o  = 1'b0;
        sr_en_o   = 1'b0;
        sr_in_o   = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        done_id_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (arb_any) begin
                    word_d  = arb_win_id ? data1_i : data0_i;
                    id_d    = arb_win_id;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                gnt0_o   = ~id_q;
                gnt1_o   = id_q;
                sr_clr_o = 1'b1;
                cnt_d    = CNT_LAST;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_en_o = 1'b1;
                sr_in_o = word_q[bit_idx];
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                done_o    = 1'b1;
                done_id_o = id_q;
                last_id_d = id_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
